// File: rtl/axi_burst_addr_gen.sv
// AXI burst address generator: takes one FIXED/INCR/WRAP burst command and
// walks its beat addresses out over a valid/ready beat interface.
module axi_burst_addr_gen #(
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 8,
    parameter int MAX_SIZE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic [1:0]        cmd_burst,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              beat_last,
    output logic [LEN_W-1:0]  beat_idx,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    // Wide enough for a 12-bit page offset plus (len+1) << 7 without overflow.
    localparam int CHK_W = (LEN_W + 9 > 14) ? LEN_W + 9 : 14;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_bytes;
    logic [1:0]        r_burst;
    logic [ADDR_W-1:0] r_wrap_lo;
    logic [ADDR_W-1:0] r_wrap_hi;
    logic              r_err;

    logic [ADDR_W-1:0] w_cmd_bytes;
    logic [ADDR_W-1:0] w_cmd_mask;
    logic [11:0]       w_cmd_page_off;
    logic [CHK_W-1:0]  w_beats;
    logic [CHK_W-1:0]  w_span;
    logic [CHK_W-1:0]  w_4k_end;
    logic              w_cross_4k;
    logic              w_wrap_len_ok;
    logic              w_unaligned;
    logic [ADDR_W-1:0] w_wrap_total;
    logic [ADDR_W-1:0] w_wrap_lo;
    logic              w_cmd_legal;
    logic              w_accept;
    logic              w_beat_fire;
    logic              w_last;
    logic [ADDR_W-1:0] w_incr_next;
    logic [ADDR_W-1:0] w_wrap_step;
    logic [ADDR_W-1:0] w_next_addr;

    // Command decode and legality checks
    assign w_cmd_bytes    = ADDR_W'(1) << cmd_size;
    assign w_cmd_mask     = w_cmd_bytes - ADDR_W'(1);
    assign w_cmd_page_off = cmd_addr[11:0] & ~w_cmd_mask[11:0];
    assign w_beats        = CHK_W'(cmd_len) + CHK_W'(1);
    assign w_span         = w_beats << cmd_size;
    assign w_4k_end       = CHK_W'(w_cmd_page_off) + w_span;
    assign w_cross_4k     = (w_4k_end > CHK_W'(4096));
    assign w_unaligned    = |(cmd_addr & w_cmd_mask);
    assign w_wrap_len_ok  = (cmd_len == LEN_W'(1)) || (cmd_len == LEN_W'(3)) ||
                            (cmd_len == LEN_W'(7)) || (cmd_len == LEN_W'(15));
    assign w_wrap_total   = ADDR_W'(w_span);
    assign w_wrap_lo      = cmd_addr & ~(w_wrap_total - ADDR_W'(1));

    always_comb begin
        w_cmd_legal = 1'b1;
        if (cmd_size > 3'(MAX_SIZE)) begin
            w_cmd_legal = 1'b0;
        end
        case (cmd_burst)
            BURST_FIXED: ;
            BURST_INCR:  if (w_cross_4k) w_cmd_legal = 1'b0;
            BURST_WRAP:  if (!w_wrap_len_ok || w_unaligned) w_cmd_legal = 1'b0;
            default:     w_cmd_legal = 1'b0;
        endcase
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state == S_ACTIVE);
    assign beat_valid  = (r_state == S_ACTIVE);
    assign beat_addr   = r_addr;
    assign beat_idx    = r_idx;
    assign cmd_err     = r_err;
    assign w_last      = (r_state == S_ACTIVE) && (r_idx == r_len);
    assign beat_last   = w_last;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_beat_fire = beat_valid && beat_ready;

    // INCR realigns after the first (possibly unaligned) beat.
    assign w_incr_next = (r_addr & ~(r_bytes - ADDR_W'(1))) + r_bytes;
    assign w_wrap_step = r_addr + r_bytes;

    always_comb begin
        w_next_addr = r_addr;
        case (r_burst)
            BURST_FIXED: w_next_addr = r_addr;
            BURST_INCR:  w_next_addr = w_incr_next;
            default:     w_next_addr = (w_wrap_step == r_wrap_hi) ? r_wrap_lo : w_wrap_step;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_bytes   <= '0;
            r_burst   <= '0;
            r_wrap_lo <= '0;
            r_wrap_hi <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept && !w_cmd_legal;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_cmd_legal) begin
                        r_state   <= S_ACTIVE;
                        r_addr    <= cmd_addr;
                        r_idx     <= '0;
                        r_len     <= cmd_len;
                        r_bytes   <= w_cmd_bytes;
                        r_burst   <= cmd_burst;
                        r_wrap_lo <= w_wrap_lo;
                        r_wrap_hi <= w_wrap_lo + w_wrap_total;
                    end
                end
                default: begin
                    if (w_beat_fire) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_addr <= w_next_addr;
                            r_idx  <= r_idx + LEN_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
